// File: rtl/mcu_console_io.sv
// rtl/mcu_console_io.sv - memory-mapped console I/O window with RX/TX FIFOs (optional IRQ: CONSOLE_IRQ_EN)
module mcu_console_io #(
  parameter logic [11:0] BASE     = 12'h7F0,
  parameter int          RX_DEPTH = 4,
  parameter int          TX_DEPTH = 4,
  parameter logic [2:0]  IRQ_VEC  = 3'd2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] addr,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        scr_valid,
  output logic [7:0]  scr_data,
  input  logic        scr_ready,
  output logic        irq,
  output logic [2:0]  irq_num
);

  localparam int RXW = $clog2(RX_DEPTH);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam logic [RXW:0] RX_ONE = 1;
  localparam logic [TXW:0] TX_ONE = 1;

  localparam logic [11:0] A_KSTAT = BASE;
  localparam logic [11:0] A_KDATA = BASE + 12'd1;
  localparam logic [11:0] A_SSTAT = BASE + 12'd2;
  localparam logic [11:0] A_SDATA = BASE + 12'd3;
  localparam logic [11:0] A_CTRL  = BASE + 12'd4;

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [RXW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TXW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [7:0]   sdata_q;
  logic [15:0]  ctrl_rd;
  logic         rx_empty, rx_full, tx_empty, tx_full;
  logic         rx_push, rx_pop, tx_push, tx_pop;
  logic         unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[15:8];

  // Pointer-based full/empty: extra MSB distinguishes full from empty
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[RXW] != rx_rp_q[RXW]) && (rx_wp_q[RXW-1:0] == rx_rp_q[RXW-1:0]);
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[TXW] != tx_rp_q[TXW]) && (tx_wp_q[TXW-1:0] == tx_rp_q[TXW-1:0]);

  assign kb_ready  = ~rx_full;
  assign scr_valid = ~tx_empty;
  // Gate the head so an empty FIFO never exposes stale or unreset storage
  assign scr_data  = tx_empty ? 8'h00 : tx_mem[tx_rp_q[TXW-1:0]];
  assign irq_num   = IRQ_VEC;

  assign rx_push = kb_valid && ~rx_full;
  assign rx_pop  = we && (addr == A_KSTAT) && ~wdata[0] && ~rx_empty;
  assign tx_push = we && (addr == A_SSTAT) && wdata[0] && ~tx_full;
  assign tx_pop  = ~tx_empty && scr_ready;

  assign rx_wp_d = rx_push ? rx_wp_q + RX_ONE : rx_wp_q;
  assign rx_rp_d = rx_pop  ? rx_rp_q + RX_ONE : rx_rp_q;
  assign tx_wp_d = tx_push ? tx_wp_q + TX_ONE : tx_wp_q;
  assign tx_rp_d = tx_pop  ? tx_rp_q + TX_ONE : tx_rp_q;

  // Register read mux; reads never alter state
  always_comb begin
    rdata = 16'h0000;
    case (addr)
      A_KSTAT: rdata = {15'b0, ~rx_empty};
      A_KDATA: rdata = rx_empty ? 16'h0000 : {8'h00, rx_mem[rx_rp_q[RXW-1:0]]};
      A_SSTAT: rdata = {15'b0, tx_full};
      A_SDATA: rdata = {8'h00, sdata_q};
      A_CTRL:  rdata = ctrl_rd;
      default: rdata = 16'h0000;
    endcase
  end

  // FIFO storage; contents are meaningless until the pointers cover them
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wp_q[RXW-1:0]] <= kb_data;
    if (tx_push) tx_mem[tx_wp_q[TXW-1:0]] <= sdata_q;
  end

  // FIFO pointers and the SDATA holding register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      sdata_q <= 8'h00;
    end else begin
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      if (we && (addr == A_SDATA)) sdata_q <= wdata[7:0];
    end
  end

`ifdef CONSOLE_IRQ_EN
  logic [1:0] ctrl_q;
  logic       irq_q;

  // Interrupt enables and registered level interrupt
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      if (we && (addr == A_CTRL)) ctrl_q <= wdata[1:0];
      irq_q <= (ctrl_q[0] && ~rx_empty) || (ctrl_q[1] && tx_empty);
    end
  end

  assign irq     = irq_q;
  assign ctrl_rd = {14'b0, ctrl_q};
`else
  assign irq     = 1'b0;
  assign ctrl_rd = 16'h0000;
`endif

endmodule

// File: tb/tb_mcu_console_io.sv
// tb/tb_mcu_console_io.sv - self-checking bench for mcu_console_io against a queue-based model
module tb_mcu_console_io;

  localparam logic [11:0] BASE = 12'h7F0;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [11:0] addr;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        scr_valid;
  logic [7:0]  scr_data;
  logic        scr_ready;
  logic        irq;
  logic [2:0]  irq_num;

  int total = 0;
  int bad = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] got[$];
  logic [7:0] hold_m;
  logic [1:0] ctrl_m;
  logic       irq_m;

  mcu_console_io dut (
    .clock(clock), .reset_n(reset_n), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
    .scr_valid(scr_valid), .scr_data(scr_data), .scr_ready(scr_ready),
    .irq(irq), .irq_num(irq_num)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rdata(input logic [11:0] a);
    if (a == BASE)              return {15'b0, rxq.size() > 0};
    if (a == BASE + 12'd1)      return (rxq.size() > 0) ? {8'h00, rxq[0]} : 16'h0000;
    if (a == BASE + 12'd2)      return {15'b0, txq.size() == DEPTH};
    if (a == BASE + 12'd3)      return {8'h00, hold_m};
    if (a == BASE + 12'd4)      return {14'b0, ctrl_m};
    return 16'h0000;
  endfunction

  // Advance one clock, updating the model from the inputs presented before the edge
  task automatic step();
    logic       rxpush, rxpop, txpush, txpop, irq_n;
    logic [7:0] kd;
    kd     = kb_data;
    rxpush = kb_valid && (rxq.size() < DEPTH);
    rxpop  = we && (addr == BASE) && !wdata[0] && (rxq.size() > 0);
    txpush = we && (addr == BASE + 12'd2) && wdata[0] && (txq.size() < DEPTH);
    txpop  = scr_ready && (txq.size() > 0);
    irq_n  = (ctrl_m[0] && rxq.size() > 0) || (ctrl_m[1] && txq.size() == 0);
    @(posedge clock);
    #1;
    if (rxpop)  void'(rxq.pop_front());
    if (rxpush) rxq.push_back(kd);
    if (txpop)  void'(txq.pop_front());
    if (txpush) txq.push_back(hold_m);
    if (we && addr == BASE + 12'd3) hold_m = wdata[7:0];
`ifdef CONSOLE_IRQ_EN
    if (we && addr == BASE + 12'd4) ctrl_m = wdata[1:0];
    irq_m = irq_n;
`else
    irq_m = 1'b0;
`endif
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [11:0] a, input logic [15:0] exp);
    addr = a; we = 1'b0;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".kb_ready"},  {15'b0, kb_ready},  {15'b0, rxq.size() < DEPTH});
    check({tag, ".scr_valid"}, {15'b0, scr_valid}, {15'b0, txq.size() > 0});
    check({tag, ".scr_data"},  {8'h00, scr_data},  (txq.size() > 0) ? {8'h00, txq[0]} : 16'h0000);
    check({tag, ".irq"},       {15'b0, irq},       {15'b0, irq_m});
  endtask

  initial begin
    reset_n = 1'b0; addr = BASE; we = 1'b0; wdata = 16'h0;
    kb_valid = 1'b0; kb_data = 8'h0; scr_ready = 1'b0;
    hold_m = 8'h0; ctrl_m = 2'b0; irq_m = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Reset state
    rdchk("rst.kstat", BASE, 16'h0000);
    rdchk("rst.sstat", BASE + 12'd2, 16'h0000);
    rdchk("rst.sdata", BASE + 12'd3, 16'h0000);
    rdchk("rst.ctrl", BASE + 12'd4, 16'h0000);
    rdchk("rst.outside", BASE + 12'd5, 16'h0000);
    check("rst.kb_ready", {15'b0, kb_ready}, 16'h0001);
    check("rst.scr_valid", {15'b0, scr_valid}, 16'h0000);
    check("rst.scr_data", {8'h0, scr_data}, 16'h0000);
    check("rst.irq", {15'b0, irq}, 16'h0000);
    check("rst.irq_num", {13'b0, irq_num}, 16'h0002);

    // "hi" through RX, then pops including one on empty
    kb_valid = 1'b1; kb_data = 8'h68; step();
    kb_data = 8'h69; step();
    kb_valid = 1'b0;
    rdchk("hi.kstat", BASE, 16'h0001);
    rdchk("hi.kdata0", BASE + 12'd1, 16'h0068);
    wr(BASE, 16'h0000);
    rdchk("hi.kdata1", BASE + 12'd1, 16'h0069);
    wr(BASE, 16'h0001);
    rdchk("hi.kdata_pop1_ignored", BASE + 12'd1, 16'h0069);
    wr(BASE, 16'h0000);
    rdchk("hi.kstat_empty", BASE, 16'h0000);
    wr(BASE, 16'h0000);
    rdchk("hi.kstat_still_empty", BASE, 16'h0000);
    rdchk("hi.kdata_empty", BASE + 12'd1, 16'h0000);

    // Five keys into a four-deep RX
    kb_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      kb_data = 8'h31 + 8'(k);
      step();
    end
    kb_data = 8'h35;
    #1 check("full.kb_ready", {15'b0, kb_ready}, 16'h0000);
    step();
    rdchk("full.head_kept", BASE + 12'd1, 16'h0031);
    wr(BASE, 16'h0000);
    check("full.kb_ready_after_pop", {15'b0, kb_ready}, 16'h0001);
    step();
    kb_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rdchk($sformatf("full.order%0d", k), BASE + 12'd1, 16'h0032 + 16'(k));
      wr(BASE, 16'h0000);
    end
    rdchk("full.drained", BASE, 16'h0000);

    // 'A','B' streamed back to back
    wr(BASE + 12'd3, 16'h0041); wr(BASE + 12'd2, 16'h0001);
    wr(BASE + 12'd3, 16'h0042); wr(BASE + 12'd2, 16'h0001);
    scr_ready = 1'b1;
    #1 check("ab.first", {7'b0, scr_valid, scr_data}, 16'h0141);
    step();
    check("ab.second", {7'b0, scr_valid, scr_data}, 16'h0142);
    step();
    check("ab.done", {15'b0, scr_valid}, 16'h0000);

    // Five sends with the screen stalled: fifth dropped
    scr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wr(BASE + 12'd3, 16'h0050 + 16'(k));
      wr(BASE + 12'd2, 16'h0001);
      if (k == 3) rdchk("tx.sstat_full", BASE + 12'd2, 16'h0001);
    end
    scr_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      #1 if (scr_valid) got.push_back(scr_data);
      step();
    end
    check("tx.count", 16'(got.size()), 16'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("tx.char%0d", k), (k < got.size()) ? {8'h0, got[k]} : 16'hFFFF, 16'h0050 + 16'(k));
    rdchk("tx.sstat_empty", BASE + 12'd2, 16'h0000);
    scr_ready = 1'b0;

`ifdef CONSOLE_IRQ_EN
    wr(BASE + 12'd4, 16'h0001);
    rdchk("irq.ctrl", BASE + 12'd4, 16'h0001);
    kb_valid = 1'b1; kb_data = 8'h78; step(); kb_valid = 1'b0;
    check("irq.not_yet", {15'b0, irq}, 16'h0000);
    step();
    check("irq.rx", {15'b0, irq}, 16'h0001);
    check("irq.num", {13'b0, irq_num}, 16'h0002);
    wr(BASE, 16'h0000);
    step();
    check("irq.rx_cleared", {15'b0, irq}, 16'h0000);
    wr(BASE + 12'd4, 16'h0002);
    step();
    check("irq.tx_empty", {15'b0, irq}, 16'h0001);
    wr(BASE + 12'd4, 16'h0000);
    step();
    check("irq.off", {15'b0, irq}, 16'h0000);
`else
    wr(BASE + 12'd4, 16'h0003);
    rdchk("noirq.ctrl", BASE + 12'd4, 16'h0000);
    step();
    check("noirq.irq", {15'b0, irq}, 16'h0000);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      kb_valid  = 1'($urandom_range(0, 1));
      kb_data   = 8'($urandom);
      scr_ready = ($urandom_range(0, 3) == 0);
      addr      = BASE + 12'($urandom_range(0, 6));
      we        = ($urandom_range(0, 2) != 0);
      wdata     = 16'($urandom);
      #1;
      check_outs($sformatf("rnd%0d", c));
      check($sformatf("rnd%0d.rdata", c), rdata, exp_rdata(addr));
      step();
    end
    we = 1'b0;

    // Reset mid-transfer discards everything at once
    kb_valid = 1'b1; scr_ready = 1'b0;
    wr(BASE + 12'd3, 16'h0077); wr(BASE + 12'd2, 16'h0001);
    reset_n = 1'b0; kb_valid = 1'b0;
    #1;
    rxq.delete(); txq.delete(); hold_m = 8'h0; ctrl_m = 2'b0; irq_m = 1'b0;
    check_outs("arst");
    rdchk("arst.kstat", BASE, 16'h0000);
    rdchk("arst.sdata", BASE + 12'd3, 16'h0000);
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
